pipe_reg_chain_arstn: RTL and testbench
=======================================

# pipe_reg_chain_arstn

Parametrised pipeline register chain with per-stage valid tracking, stall, flush and bubble insertion. It is a drop-in successor to the fixed inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the 64-bit pipelined core. Each pipeline boundary becomes one instance with a packed payload bus. The hazard unit drives it directly: stall freezes the stage, flush kills in-flight instructions, bubble injects a NOP.

## Interface

Parameters:
- DATA_W, 64, payload width in bits (packed data plus control fields); must be ≥ 1
- DEPTH, 1, number of register stages in the chain; must be ≥ 1
- PRESET_VAL, 0, value loaded into every payload register on reset and on bubble injection

Ports:
- clk  input  1  rising-edge clock; the block uses this single clock only
- arst_n  input  1  reset, asynchronous and active-low
- en  input  1  advance enable; 0 = stall (hold all stages)
- flush  input  1  synchronous kill of all in-flight valid bits
- bubble  input  1  inject NOP into stage 0 instead of din
- din_valid  input  1  din carries a real instruction
- din  input  DATA_W  payload into stage 0
- dout_valid  output  1  valid bit of last stage
- dout  output  DATA_W  payload of last stage
- occupancy  output  OCC_W = $clog2(DEPTH+1), minimum 1  registered count of valid stages
- stall_cnt  output  32  stall statistics counter; present only with PIPE_REG_CHAIN_STATS_EN

## Operation

Reset (arst_n = 0, takes effect immediately regardless of clk):
- All payload registers = PRESET_VAL.
- All valid bits = 0; occupancy = 0; stall_cnt = 0.
- Therefore dout = PRESET_VAL and dout_valid = 0.

Per rising edge, evaluated in priority order:
1. **flush = 1**
   - All valid bits ← 0, whatever the value of en.
   - Payload registers follow the en/bubble rules below; flush does not touch data.
2. **en = 0**
   - Every payload and valid register holds.
   - din, din_valid and bubble are ignored.
3. **en = 1**
   - Stage k ← stage k−1 for k = 1..DEPTH−1, payload and valid together.
   - Stage 0 loads din, with valid ← din_valid.
   - If bubble = 1, stage 0 payload ← PRESET_VAL and valid ← 0 instead.

Occupancy:
- Register updated each edge to the popcount of the next-state valid vector.
- Never exceeds DEPTH.
- Equals 0 on the cycle after any flush.

Simultaneous events:
- flush + en = 1 + bubble = 1: stage 0 payload = PRESET_VAL, other payloads shift, all valids 0.
- flush + en = 0: payload holds, valids 0.
- bubble with en = 0: no effect.
- din_valid = 0 with en = 1 (bubble = 0): din is still captured and propagates with valid 0.

Reset asserted mid-stream:
- All in-flight entries are discarded at once.
- After release, the first edge with en = 1 loads stage 0 normally.

## Timing

- Latency: DEPTH cycles from din capture to dout with en held high; each en = 0 cycle adds one.
- dout, dout_valid and occupancy are pure register outputs; there is no combinational path from any input to any output.
- flush and bubble act on the same edge they are sampled high.
- Valid bits, occupancy and stall_cnt are internally consistent on every cycle.

## Configuration

- Macro: PIPE_REG_CHAIN_STATS_EN.
- **Defined:**
  - stall_cnt is present: a 32-bit counter that increments on every edge where en = 0 and occupancy ≠ 0.
  - It saturates at 0xFFFF_FFFF and clears only on reset; flush does not clear it.
- **Undefined:**
  - The stall_cnt port and its logic are absent.
  - All other behaviour is identical.

## Test plan

- **Reset:** DATA_W = 64, DEPTH = 3, PRESET_VAL = 0; assert arst_n = 0 mid-cycle -> dout = 0, dout_valid = 0 and occupancy = 0 immediately, without waiting for a clock edge.
- **Streaming:** DEPTH = 3, en = 1; din = 0xA, 0xB, 0xC with din_valid = 1 on consecutive edges -> dout = 0xA with dout_valid = 1 on the 3rd edge after capture, then 0xB, then 0xC; occupancy reads 1, 2, 3.
- **Stall:** stall 2 cycles with 0xA in stage 1 -> dout output delayed exactly 2 cycles; all stage contents unchanged during the stall; stall_cnt = 2 with the macro defined.
- **Flush:** pipeline full (occupancy = 3); pulse flush with en = 0 -> next cycle occupancy = 0, dout_valid = 0, dout payload unchanged.
- **Bubble:** en = 1, bubble = 1, din = 0xFF, din_valid = 1 -> stage 0 holds PRESET_VAL with valid 0; DEPTH cycles later dout = PRESET_VAL with dout_valid = 0.
- **Saturation:** macro defined; force stall_cnt to 0xFFFF_FFFE, then stall 3 cycles with occupancy ≠ 0 -> stall_cnt stays at 0xFFFF_FFFF.

Source files
------------

// File: rtl/pipe_reg_chain_arstn.sv
// Pipeline register chain with per-stage valid bits, stall (en), flush and bubble injection.
// Optional stall statistics counter enabled by defining PIPE_REG_CHAIN_STATS_EN.
module pipe_reg_chain_arstn #(
  parameter int                DATA_W     = 64,
  parameter int                DEPTH      = 1,
  parameter logic [DATA_W-1:0] PRESET_VAL = '0,
  localparam int               OCC_W      = ($clog2(DEPTH+1) > 1) ? $clog2(DEPTH+1) : 1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              en,
  input  logic              flush,
  input  logic              bubble,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din,
  output logic              dout_valid,
  output logic [DATA_W-1:0] dout,
`ifdef PIPE_REG_CHAIN_STATS_EN
  output logic [31:0]       stall_cnt,
`endif
  output logic [OCC_W-1:0]  occupancy
);

  logic [DEPTH-1:0][DATA_W-1:0] data_reg;
  logic [DEPTH-1:0][DATA_W-1:0] data_next;
  logic [DEPTH-1:0]             valid_reg;
  logic [DEPTH-1:0]             valid_next;
  logic [OCC_W-1:0]             occ_reg;
  logic [OCC_W-1:0]             occ_next;

  // Stage 0 takes din or a NOP; flush only kills the valid bit, never the payload.
  assign data_next[0]  = !en    ? data_reg[0] :
                         bubble ? PRESET_VAL  : din;
  assign valid_next[0] = flush  ? 1'b0        :
                         !en    ? valid_reg[0] :
                         bubble ? 1'b0        : din_valid;

  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
      assign data_next[gi]  = en ? data_reg[gi-1] : data_reg[gi];
      assign valid_next[gi] = flush ? 1'b0 :
                              en    ? valid_reg[gi-1] : valid_reg[gi];
    end
  endgenerate

  always_comb begin
    occ_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_next = occ_next + OCC_W'(valid_next[i]);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      data_reg  <= {DEPTH{PRESET_VAL}};
      valid_reg <= '0;
      occ_reg   <= '0;
    end else begin
      data_reg  <= data_next;
      valid_reg <= valid_next;
      occ_reg   <= occ_next;
    end
  end

  assign dout       = data_reg[DEPTH-1];
  assign dout_valid = valid_reg[DEPTH-1];
  assign occupancy  = occ_reg;

`ifdef PIPE_REG_CHAIN_STATS_EN
  logic [31:0] stall_cnt_reg;

  // Counts stalled edges while something is in flight; saturates, cleared only by reset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cnt_reg <= '0;
    end else if (!en && (occ_reg != '0) && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_reg_chain_arstn.sv
// Directed, table-driven bench for pipe_reg_chain_arstn (DATA_W=64, DEPTH=3, PRESET_VAL=0).
// Stall counter checks are compiled in when PIPE_REG_CHAIN_STATS_EN is defined.
module tb_pipe_reg_chain_arstn;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 3;

  logic              clk;
  logic              arst_n;
  logic              en;
  logic              flush;
  logic              bubble;
  logic              din_valid;
  logic [DATA_W-1:0] din;
  logic              dout_valid;
  logic [DATA_W-1:0] dout;
  logic [1:0]        occupancy;
`ifdef PIPE_REG_CHAIN_STATS_EN
  logic [31:0]       stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pipe_reg_chain_arstn #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .PRESET_VAL (64'h0)
  ) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .en         (en),
    .flush      (flush),
    .bubble     (bubble),
    .din_valid  (din_valid),
    .din        (din),
    .dout_valid (dout_valid),
    .dout       (dout),
`ifdef PIPE_REG_CHAIN_STATS_EN
    .stall_cnt  (stall_cnt),
`endif
    .occupancy  (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        flush;
    logic        bubble;
    logic        dv;
    logic [63:0] din;
    logic        exp_dv;
    logic [63:0] exp_dout;
    logic [1:0]  exp_occ;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic exp_dv, input logic [63:0] exp_dout,
                           input logic [1:0] exp_occ);
    check({tag, ".dout_valid"}, 64'(dout_valid), 64'(exp_dv));
    check({tag, ".dout"}, dout, exp_dout);
    check({tag, ".occupancy"}, 64'(occupancy), 64'(exp_occ));
  endtask

  task automatic step(input logic e, input logic f, input logic b, input logic dv,
                      input logic [63:0] d);
    en = e; flush = f; bubble = b; din_valid = dv; din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // en flush bubble dv din | exp_dv exp_dout exp_occ
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 64'hA,  1'b0, 64'h0,  2'd1};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 64'hB,  1'b0, 64'h0,  2'd2};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 64'hC,  1'b1, 64'hA,  2'd3};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 64'h0,  1'b1, 64'hB,  2'd2};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 64'h11, 1'b1, 64'hC,  2'd1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 64'h22, 1'b0, 64'h0,  2'd0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 64'hFF, 1'b0, 64'h11, 2'd0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 64'h33, 1'b0, 64'h22, 2'd1};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 64'h44, 1'b0, 64'h0,  2'd2};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 64'h55, 1'b1, 64'h33, 2'd3};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 64'hEE, 1'b0, 64'h33, 2'd0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 64'h66, 1'b0, 64'h44, 2'd1};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 64'h77, 1'b0, 64'h55, 2'd0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 64'h88, 1'b0, 64'h66, 2'd1};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 64'h99, 1'b0, 64'h66, 2'd1};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 64'hAA, 1'b0, 64'h0,  2'd1};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 64'hBB, 1'b1, 64'h88, 2'd1};

    arst_n = 1'b0; en = 1'b0; flush = 1'b0; bubble = 1'b0; din_valid = 1'b0; din = '0;
    #12;
    check_out("por", 1'b0, 64'h0, 2'd0);
`ifdef PIPE_REG_CHAIN_STATS_EN
    check("por.stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    @(negedge clk);
    arst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].en, vecs[i].flush, vecs[i].bubble, vecs[i].dv, vecs[i].din);
      $display("vec %0d en=%b fl=%b bu=%b dv=%b din=%0h -> dout_valid=%b dout=%0h occ=%0d",
               i, vecs[i].en, vecs[i].flush, vecs[i].bubble, vecs[i].dv, vecs[i].din,
               dout_valid, dout, occupancy);
      check_out($sformatf("vec%0d", i), vecs[i].exp_dv, vecs[i].exp_dout, vecs[i].exp_occ);
    end

    // Asynchronous reset mid-cycle, away from any clock edge, with a valid entry at dout.
    #2;
    arst_n = 1'b0;
    #1;
    $display("mid-cycle reset -> dout_valid=%b dout=%0h occ=%0d", dout_valid, dout, occupancy);
    check_out("arst", 1'b0, 64'h0, 2'd0);
`ifdef PIPE_REG_CHAIN_STATS_EN
    check("arst.stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    @(negedge clk);
    arst_n = 1'b1;

    // Stall sequence: 0xA sits in stage 1 for two stalled edges, then reaches dout.
    step(1'b1, 1'b0, 1'b0, 1'b1, 64'hA);
    $display("stall load A -> occ=%0d", occupancy);
    check_out("stall.load0", 1'b0, 64'h0, 2'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 64'hB);
    $display("stall load B -> occ=%0d", occupancy);
    check_out("stall.load1", 1'b0, 64'h0, 2'd2);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 64'hDEAD);
      $display("stall hold %0d -> dout_valid=%b dout=%0h occ=%0d", i, dout_valid, dout, occupancy);
      check_out($sformatf("stall.hold%0d", i), 1'b0, 64'h0, 2'd2);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    $display("stall release -> dout_valid=%b dout=%0h occ=%0d", dout_valid, dout, occupancy);
    check_out("stall.out", 1'b1, 64'hA, 2'd2);
`ifdef PIPE_REG_CHAIN_STATS_EN
    check("stall.stall_cnt", 64'(stall_cnt), 64'd2);

    // Saturation: preload near the top, then stall with occupancy nonzero.
    #2;
    force dut.stall_cnt_reg = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_reg;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
      $display("sat stall %0d -> stall_cnt=%0h", i, stall_cnt);
      check($sformatf("sat%0d.stall_cnt", i), 64'(stall_cnt), 64'hFFFF_FFFF);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    $display("sat flush -> stall_cnt=%0h occ=%0d", stall_cnt, occupancy);
    check("sat.flush.stall_cnt", 64'(stall_cnt), 64'hFFFF_FFFF);
    check("sat.flush.occupancy", 64'(occupancy), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
